// File: rtl/perm_walker.sv
// perm_walker
// -----------
// Walks every permutation of an N-input LUT with Heap's algorithm, one per
// step. Each permutation drives the combinational enumerator as a one-hot
// pin map (prm_o). The returned index (enm_i) is then streamed out with the
// permutation and its sequence number on a valid/ready interface.
//
// Optional build macro: PERM_WALKER_ENM_REG_EN
//   defined   : enm_i is registered in a SETTLE cycle, and out_enm comes from
//               that register. This breaks the enumerator path at the cost of
//               one extra cycle per triple.
//   undefined : out_enm follows enm_i combinationally while a triple is
//               presented. SETTLE is never entered.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : begin a sweep (honoured in IDLE only)
//   abort      : stop the sweep and return to IDLE; outranks start
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse after the final triple is accepted
//   prm_o      : to enumerator; field k = prm_o[N*k +: N], one-hot, names the
//                physical input placed on LUT pin k
//   enm_i      : index returned by the enumerator for prm_o
//   out_valid  : a triple is presented
//   out_ready  : sink accepts the triple
//   out_cnt    : sequence number 0..N!-1
//   out_prm    : permutation being reported (same as prm_o)
//   out_enm    : enumerator result for out_prm
module perm_walker #(
  parameter int N  = 6,
  parameter int EW = 9,
  parameter int CW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [N*N-1:0]  prm_o,
  input  logic [EW-1:0]   enm_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_cnt,
  output logic [N*N-1:0]  out_prm,
  output logic [EW-1:0]   out_enm
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;

  function automatic int fact(input int n);
    int r;
    r = 1;
    for (int k = 2; k <= n; k++) r = r * k;
    return r;
  endfunction

  localparam int            NFACT    = fact(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(NFACT - 1);
  localparam logic [N-1:0]  PIN_ONE  = N'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_EMIT    = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Every new permutation (including the first) either settles through the
  // enumerator register or is presented immediately.
`ifdef PERM_WALKER_ENM_REG_EN
  localparam logic [2:0] S_NEW_PERM = S_SETTLE;
`else
  localparam logic [2:0] S_NEW_PERM = S_EMIT;
`endif

  logic [2:0]    state_reg, state_next;
  logic [AW-1:0] a_reg [N];
  logic [AW-1:0] a_next [N];
  // c_reg[0] is never used by the walk; it is kept so that the Heap level
  // counter can index the array directly.
  logic [AW-1:0] c_reg [N];
  logic [AW-1:0] c_next [N];
  logic [AW-1:0] i_reg, i_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [AW-1:0] swap_j;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      for (int k = 0; k < N; k++) begin
        a_reg[k] <= AW'(k);
        c_reg[k] <= '0;
      end
      i_reg   <= AW'(1);
      cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      c_reg     <= c_next;
      i_reg     <= i_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    c_next     = c_reg;
    i_next     = i_reg;
    cnt_next   = cnt_reg;
    swap_j     = '0;

    if (state_reg != S_IDLE && abort) begin
      // Walk state is frozen; only the FSM returns home. A handshake in this
      // cycle is accepted by the sink but not counted here.
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start && !abort) begin
            for (int k = 0; k < N; k++) begin
              a_next[k] = AW'(k);
              c_next[k] = '0;
            end
            i_next     = AW'(1);
            cnt_next   = '0;
            state_next = S_NEW_PERM;
          end
        end

        S_SETTLE: begin
          state_next = S_EMIT;
        end

        S_EMIT: begin
          if (out_ready) begin
            if (cnt_reg == LAST_CNT) begin
              state_next = S_DONE;
            end else begin
              cnt_next   = cnt_reg + CW'(1);
              state_next = S_ADVANCE;
            end
          end
        end

        S_ADVANCE: begin
          // One level of the iterative Heap walk per cycle. A swap ends the
          // step; an exhausted level resets its counter and moves up.
          if (c_reg[i_reg] < i_reg) begin
            swap_j           = i_reg[0] ? c_reg[i_reg] : '0;
            a_next[swap_j]   = a_reg[i_reg];
            a_next[i_reg]    = a_reg[swap_j];
            c_next[i_reg]    = c_reg[i_reg] + AW'(1);
            i_next           = AW'(1);
            state_next       = S_NEW_PERM;
          end else begin
            c_next[i_reg] = '0;
            i_next        = i_reg + AW'(1);
          end
        end

        S_DONE: begin
          state_next = S_IDLE;
        end

        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // One-hot pin map decoded straight from the index array.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_prm
      assign prm_o[N*gi +: N] = PIN_ONE << a_reg[gi];
    end
  endgenerate

  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign out_valid = (state_reg == S_EMIT);
  assign out_cnt   = cnt_reg;
  assign out_prm   = prm_o;

`ifdef PERM_WALKER_ENM_REG_EN
  logic [EW-1:0] enm_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enm_reg <= '0;
    end else if (state_reg == S_SETTLE && !abort) begin
      enm_reg <= enm_i;
    end
  end

  assign out_enm = enm_reg;
`else
  // Passed through while a triple is presented; held at zero otherwise so
  // the idle/reset value does not depend on the enumerator.
  assign out_enm = out_valid ? enm_i : '0;
`endif

endmodule

// File: tb/tb_perm_walker.sv
module tb_perm_walker;

  localparam int N  = 6;
  localparam int EW = 9;
  localparam int CW = 10;
  localparam int NF = 720;
  localparam logic [35:0] ID_PRM  = 36'h810204081;
  localparam logic [35:0] SEC_PRM = 36'h810204042;
`ifdef PERM_WALKER_ENM_REG_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif

  typedef struct packed {
    logic [9:0]  cnt;
    logic [35:0] prm;
    logic [8:0]  enm;
  } trip_t;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic        busy, done, out_valid;
  logic [35:0] prm_o, out_prm;
  logic [8:0]  enm_i, out_enm;
  logic [9:0]  out_cnt;

  always #5 clk = ~clk;

  perm_walker #(.N(N), .EW(EW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .prm_o(prm_o), .enm_i(enm_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt),
    .out_prm(out_prm), .out_enm(out_enm)
  );

  // Enumerator stand-in: Lehmer rank of the pin map, low 9 bits.
  function automatic logic [8:0] enum_of(input logic [35:0] p);
    int idx [6];
    int r, s, f;
    for (int k = 0; k < 6; k++) begin
      idx[k] = 0;
      for (int b = 0; b < 6; b++) if (p[6*k+b]) idx[k] = b;
    end
    r = 0;
    for (int k = 0; k < 6; k++) begin
      s = 0;
      for (int j = k + 1; j < 6; j++) if (idx[j] < idx[k]) s++;
      f = 1;
      for (int m = 2; m <= 5 - k; m++) f = f * m;
      r = r + s * f;
    end
    return r[8:0];
  endfunction

  assign enm_i = enum_of(prm_o);

  // ---------------- reference model ----------------
  int    a [6];
  trip_t ref_list[$];
  trip_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    done_cnt = 0;
  int    ready_mode = 0;
  logic [35:0] first_prm [2];

  function automatic void emit_ref();
    trip_t t;
    int used [6];
    int r, below;
    t.cnt = 10'(ref_list.size());
    t.prm = '0;
    for (int k = 0; k < 6; k++) t.prm[6*k + a[k]] = 1'b1;
    for (int k = 0; k < 6; k++) used[k] = 0;
    r = 0;
    for (int k = 0; k < 6; k++) begin
      below = 0;
      for (int v = 0; v < a[k]; v++) if (used[v] == 0) below++;
      used[a[k]] = 1;
      r = r * (6 - k) + below;
    end
    t.enm = r[8:0];
    ref_list.push_back(t);
  endfunction

  // Heap's rule for a level of size k after its j-th sub-walk.
  function automatic void hswap(input int k, input int j);
    int t;
    if (k % 2 == 0) begin
      t = a[j]; a[j] = a[k-1]; a[k-1] = t;
    end else begin
      t = a[0]; a[0] = a[k-1]; a[k-1] = t;
    end
  endfunction

  // Recursive Heap's algorithm unrolled into nested loops for N=6.
  function automatic void build_ref();
    for (int k = 0; k < 6; k++) a[k] = k;
    ref_list.delete();
    for (int j6 = 0; j6 < 6; j6++) begin
      for (int j5 = 0; j5 < 5; j5++) begin
        for (int j4 = 0; j4 < 4; j4++) begin
          for (int j3 = 0; j3 < 3; j3++) begin
            for (int j2 = 0; j2 < 2; j2++) begin
              emit_ref();
              if (j2 < 1) hswap(2, j2);
            end
            if (j3 < 2) hswap(3, j3);
          end
          if (j4 < 3) hswap(4, j4);
        end
        if (j5 < 4) hswap(5, j5);
      end
      if (j6 < 5) hswap(6, j6);
    end
  endfunction

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_expected(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(ref_list[k]);
  endtask

  // ---------------- monitor ----------------
  logic        stall_q = 1'b0;
  logic [54:0] held;
  trip_t       mon_e;
  bit          mon_oh;
  bit          seen [logic [35:0]];

  always @(negedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (stall_q) begin
        check(out_valid, "stall_valid_hold", 64'(out_valid), 64'd1);
        check({out_cnt, out_prm, out_enm} == held, "stall_stable",
              64'({out_cnt, out_prm, out_enm}), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_triple", 64'(out_cnt), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check(out_cnt == mon_e.cnt, "out_cnt", 64'(out_cnt), 64'(mon_e.cnt));
          check(out_prm == mon_e.prm, "out_prm", 64'(out_prm), 64'(mon_e.prm));
          check(out_enm == mon_e.enm, "out_enm", 64'(out_enm), 64'(mon_e.enm));
        end
        mon_oh = 1'b1;
        for (int k = 0; k < 6; k++) if (!$onehot(out_prm[6*k +: 6])) mon_oh = 1'b0;
        check(mon_oh, "prm_onehot", 64'(out_prm), 64'(mon_e.prm));
        if (out_cnt == 10'd0) seen.delete();
        check(!seen.exists(out_prm), "prm_distinct", 64'(out_prm), 64'(out_cnt));
        seen[out_prm] = 1'b1;
        if (out_cnt < 10'd2) first_prm[out_cnt[0]] = out_prm;
      end
      stall_q <= out_valid && !out_ready;
      held    <= {out_cnt, out_prm, out_enm};
    end
  end

  // ---------------- sink ready driver ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) out_ready = 1'b1;
      else out_ready = ($urandom_range(0, 99) >= 30);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_start(output int lat);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (!done && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check(done, "done_seen", 64'(done), 64'd1);
    @(posedge clk); #1;
    check(!busy && !done, "idle_after_done", 64'({busy, done}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "queue_drained", 64'(exp_q.size()), 64'd0);
    check(done_cnt - d0 == 1, "single_done", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(busy == 1'b0, {tag, "_busy"}, 64'(busy), 64'd0);
    check(done == 1'b0, {tag, "_done"}, 64'(done), 64'd0);
    check(out_valid == 1'b0, {tag, "_valid"}, 64'(out_valid), 64'd0);
    check(out_cnt == 10'd0, {tag, "_cnt"}, 64'(out_cnt), 64'd0);
    check(out_prm == ID_PRM, {tag, "_prm"}, 64'(out_prm), 64'(ID_PRM));
    check(prm_o == ID_PRM, {tag, "_prm_o"}, 64'(prm_o), 64'(ID_PRM));
    check(out_enm == 9'd0, {tag, "_enm"}, 64'(out_enm), 64'd0);
  endtask

  initial begin
    int lat, d0, n;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    build_ref();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // Full sweep, sink always ready.
    d0 = done_cnt;
    push_expected(NF);
    do_start(lat);
    check(lat == EXP_LAT, "start_latency", 64'(lat), 64'(EXP_LAT));
    wait_done(d0);
    check(first_prm[0] == ID_PRM, "first_prm", 64'(first_prm[0]), 64'(ID_PRM));
    check(first_prm[1] == SEC_PRM, "second_prm", 64'(first_prm[1]), 64'(SEC_PRM));
    $display("sweep ready=1 complete, checks so far %0d", checks);

    // Abort while presenting triple 100 with the sink ready.
    d0 = done_cnt;
    push_expected(101);
    do_start(lat);
    n = 0;
    while (!(out_valid && out_cnt == 10'd100) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check(out_valid && out_cnt == 10'd100, "reach_cnt100", 64'(out_cnt), 64'd100);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check(!out_valid && !busy && !done, "abort_idle",
          64'({out_valid, busy, done}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check(done_cnt == d0, "abort_no_done", 64'(done_cnt - d0), 64'd0);
    check(exp_q.size() == 0, "abort_queue", 64'(exp_q.size()), 64'd0);
    $display("abort at out_cnt=100 complete");

    // start together with abort in IDLE is ignored.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check(!busy, "start_abort_idle", 64'(busy), 64'd0);

    // Restart under random backpressure: sequence must restart from 0.
    ready_mode = 1;
    d0 = done_cnt;
    push_expected(NF);
    do_start(lat);
    check(lat == EXP_LAT, "restart_latency", 64'(lat), 64'(EXP_LAT));
    wait_done(d0);
    ready_mode = 0;
    $display("sweep with backpressure complete, checks so far %0d", checks);

    // Asynchronous reset during ADVANCE at out_cnt=400.
    push_expected(400);
    do_start(lat);
    n = 0;
    while (!(busy && !out_valid && out_cnt == 10'd400) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check(busy && !out_valid && out_cnt == 10'd400, "reach_advance400",
          64'(out_cnt), 64'd400);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    check(exp_q.size() == 0, "rst_queue", 64'(exp_q.size()), 64'd0);
    @(negedge clk) rst = 1'b0;
    $display("async reset at out_cnt=400 complete");

    // Clean sweep after reset.
    d0 = done_cnt;
    push_expected(NF);
    do_start(lat);
    check(lat == EXP_LAT, "post_rst_latency", 64'(lat), 64'(EXP_LAT));
    wait_done(d0);
    $display("sweep after reset complete");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/perm_walker.md
# perm_walker

Sequencer that walks every input permutation of an N-input LUT and drives the combinational `enumerate` block. It generates permutations one at a time with Heap's algorithm and presents each as a one-hot `prm` vector to the enumerator. It then captures the returned `enm` index and streams each {sequence number, permutation, index} triple out on a valid/ready interface. It is the driver used for exhaustive enumeration sweeps and for building permutation-to-index tables.

## Interface
- `N`, default 6: number of LUT inputs. The enumerator instance shipped today is N=6.
- `EW`, default 9: width of the enumerator's `enm` output.
- `CW`, default 10: width of the sequence counter; must hold N!-1 (719 for N=6).
- `clk` (input, 1): single clock; all state updates on the rising edge.
- `rst` (input, 1): asynchronous, active-high reset.
- `start` (input, 1): begin a sweep; accepted only in IDLE.
- `abort` (input, 1): terminate the sweep; the block returns to IDLE on the next edge.
- `busy` (output, 1): high in every state except IDLE.
- `done` (output, 1): one-cycle pulse after the last triple is accepted.
- `prm_o` (output, N*N): to the enumerator. Field k = `prm_o[N*k +: N]` is one-hot and names the physical input on LUT pin k.
- `enm_i` (input, EW): from the enumerator.
- `out_valid` (output, 1), `out_ready` (input, 1): output handshake.
- `out_cnt` (output, CW): sequence number, 0..N!-1.
- `out_prm` (output, N*N): the permutation being reported.
- `out_enm` (output, EW): the enumerator result for `out_prm`.

## Operation
- State: index array A[0..N-1] with entries of $clog2(N) bits, and Heap counters c[1..N-1].
- `prm_o` is decoded combinationally from A; `out_prm` equals `prm_o`.
- States are IDLE, SETTLE, EMIT, ADVANCE, DONE.
- IDLE:
  - On `start`: A[k]=k, all c=0, `out_cnt`=0, i=1.
  - Go to SETTLE if `PERM_WALKER_ENM_REG_EN` is defined, otherwise to EMIT.
- SETTLE: one cycle, during which `enm_i` is registered. Then go to EMIT.
- EMIT:
  - `out_valid`=1.
  - On `out_valid && out_ready`: if `out_cnt` = N!-1, go to DONE. Otherwise increment `out_cnt` and go to ADVANCE.
- ADVANCE performs one Heap step per cycle:
  - If c[i] < i: for even i, swap A[0] with A[i]; for odd i, swap A[c[i]] with A[i]. Then c[i]++, i=1, and go to SETTLE or EMIT as configured.
  - Otherwise: c[i]=0, i++, and stay in ADVANCE.
  - i never reaches N before the final permutation, because termination is by `out_cnt`.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `abort`:
  - Takes priority in every non-IDLE state; next state is IDLE.
  - The sequence counter, A and c hold their values; `done` is not pulsed.
  - A handshake in the same cycle as `abort` is still counted as accepted by the sink, and the sequence stops.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: `abort` wins and `start` is ignored.

## Timing
- Reset values: IDLE, `busy`=0, `done`=0, `out_valid`=0, `out_cnt`=0, A = identity, c=0.
  - `prm_o`/`out_prm` = identity (36'h810204081 for N=6), `out_enm`=0.
- Start to first `out_valid`:
  - Without the macro: 1 cycle (`start` edge, then EMIT).
  - With the macro: 2 cycles.
- Between triples: 1 cycle of ADVANCE per scanned level, plus 1 SETTLE cycle when the macro is enabled.
  - The worst case is N-1 ADVANCE cycles.
- Output stability while `out_valid`=1 and `out_ready`=0:
  - `out_cnt`, `out_prm` and `out_enm` hold stable.
  - `prm_o` does not change, so the combinational `out_enm` stays valid.
- `out_valid` never drops without a handshake, except on `abort` or `rst`.
- `done` is asserted the cycle after the final handshake; `busy` falls the cycle after that.
- Asynchronous `rst` mid-sweep: all outputs take their reset values immediately.

## Configuration
- `PERM_WALKER_ENM_REG_EN` defined:
  - `enm_i` is registered in SETTLE, and `out_enm` comes from that register.
  - Cuts the enumerator's long combinational path from the output timing; costs one cycle per triple.
- Not defined:
  - `out_enm` = `enm_i` combinationally and SETTLE is never entered.
  - Triple rate is up to one per ADVANCE+EMIT pair.

## Test plan
- Reset, then `start` with `out_ready`=1 held.
  - First triple: `out_cnt`=0, `out_prm`=36'h810204081.
  - Second triple: `out_cnt`=1, `out_prm`=36'h810204042 (A=[1,0,2,3,4,5]).
- Full sweep with `out_ready`=1:
  - Exactly 720 handshakes with `out_cnt` 0..719.
  - All 720 `out_prm` values are distinct and every field is one-hot.
  - A single `done` pulse; `busy`=0 afterwards.
- Random `out_ready` backpressure (about 30% low):
  - Outputs are stable while stalled.
  - The sequence is identical to the no-stall run; no triple is lost or duplicated.
- `abort` in EMIT at `out_cnt`=100:
  - The block is in IDLE on the next cycle with `out_valid`=0 and no `done`.
  - A later `start` restarts at `out_cnt`=0 with the identity permutation.
- Assert `rst` during ADVANCE at `out_cnt`=400: outputs go to reset values immediately.
- Run the sweep with and without `PERM_WALKER_ENM_REG_EN`:
  - The {`out_cnt`, `out_prm`, `out_enm`} streams are identical.
  - Each `out_enm` matches a golden enumerator model.
  - Start-to-first-valid latency is 1 cycle without the macro and 2 cycles with it.
